// File: rtl/pb_debounce.sv
// Synchronizer, debouncer and press/release/long-press detector for active-low
// push-button pins. Each channel is independent; every output is registered.
module pb_debounce #(
  parameter int N             = 2,
  parameter int STABLE_CYCLES = 65536,
  parameter int LONG_CYCLES   = 4194304
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] nPB,
  output logic [N-1:0] pressed,
  output logic [N-1:0] press_p,
  output logic [N-1:0] release_p,
  output logic [N-1:0] long_p,
  output logic [N-1:0] held_long
);

  localparam int SW = $clog2(STABLE_CYCLES);
  localparam int LW = $clog2(LONG_CYCLES);

  localparam logic [SW-1:0] DCNT_LAST = SW'(STABLE_CYCLES - 1);
  localparam logic [LW-1:0] HCNT_LAST = LW'(LONG_CYCLES - 1);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } hold_state_t;

  for (genvar i = 0; i < N; i++) begin : g_ch
    logic [1:0]    sync_q;
    logic          s;
    logic [SW-1:0] dcnt_q, dcnt_d;
    logic          pressed_q, pressed_d;
    logic          press_q, press_d;
    logic          release_q, release_d;
    hold_state_t   state_q, state_d;
    logic [LW-1:0] hcnt_q, hcnt_d;
    logic          long_q, long_d;
    logic          held_q, held_d;

    // Flops reset to the released pin level so a held button after reset is
    // seen as a fresh press.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        sync_q <= 2'b11;
      end else begin
        sync_q <= {sync_q[0], nPB[i]};
      end
    end

    assign s = ~sync_q[1];

    always_comb begin
      dcnt_d    = dcnt_q;
      pressed_d = pressed_q;
      press_d   = 1'b0;
      release_d = 1'b0;
      if (s == pressed_q) begin
        dcnt_d = '0;
      end else if (dcnt_q == DCNT_LAST) begin
        dcnt_d    = '0;
        pressed_d = s;
        press_d   = s;
        release_d = ~s;
      end else begin
        dcnt_d = dcnt_q + SW'(1);
      end
    end

    // Hold tracker. A release accepted on the threshold edge takes priority,
    // so long_p never fires together with release_p.
    always_comb begin
      state_d = state_q;
      hcnt_d  = hcnt_q;
      long_d  = 1'b0;
      held_d  = held_q;
      case (state_q)
        IDLE: begin
          hcnt_d = '0;
          held_d = 1'b0;
          if (press_d) begin
            state_d = HOLD;
          end
        end
        HOLD: begin
          if (release_d) begin
            state_d = IDLE;
            hcnt_d  = '0;
            held_d  = 1'b0;
          end else if (hcnt_q == HCNT_LAST) begin
            if (!held_q) begin
              long_d = 1'b1;
              held_d = 1'b1;
            end
          end else begin
            hcnt_d = hcnt_q + LW'(1);
          end
        end
        default: begin
          state_d = IDLE;
          hcnt_d  = '0;
          held_d  = 1'b0;
        end
      endcase
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        dcnt_q    <= '0;
        pressed_q <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
        state_q   <= IDLE;
        hcnt_q    <= '0;
        long_q    <= 1'b0;
        held_q    <= 1'b0;
      end else begin
        dcnt_q    <= dcnt_d;
        pressed_q <= pressed_d;
        press_q   <= press_d;
        release_q <= release_d;
        state_q   <= state_d;
        hcnt_q    <= hcnt_d;
        long_q    <= long_d;
        held_q    <= held_d;
      end
    end

    assign pressed[i]   = pressed_q;
    assign press_p[i]   = press_q;
    assign release_p[i] = release_q;
    assign long_p[i]    = long_q;
    assign held_long[i] = held_q;
  end

endmodule

// File: doc/pb_debounce.md
# pb_debounce

Per-button synchronizer, debouncer and edge/long-press detector for raw active-low push-button pins. Sits directly upstream of the top-level LED/blink logic. Converts the asynchronous, bouncing `nPB` pins into a clean active-high `pressed` level plus single-cycle press, release and long-press pulses, all in the `clk` domain. The top level then uses `pressed` in place of raw pin reads.

## Interface

Parameters:
- `N` — default 2 — number of independent button channels.
- `STABLE_CYCLES` — default 65536 — consecutive identical synchronized samples required to accept a level change; legal range ≥ 2.
- `LONG_CYCLES` — default 4194304 — clocks a press must be held, counted from acceptance, before `long_p` fires; legal range ≥ 2.
- Counter widths: `$clog2(STABLE_CYCLES)` and `$clog2(LONG_CYCLES)`, computed internally.

Ports:
- `clk` — in — 1 — single clock; all logic on rising edge.
- `rst` — in — 1 — reset, asynchronous, active-high.
- `nPB` — in — N — raw button pins, active-low, asynchronous to `clk`.
- `pressed` — out — N — debounced level; 1 = pressed.
- `press_p` — out — N — one-cycle pulse on accepted press.
- `release_p` — out — N — one-cycle pulse on accepted release.
- `long_p` — out — N — one-cycle pulse when the long-press threshold is reached.
- `held_long` — out — N — level; 1 from the `long_p` cycle until the release is accepted.

## Operation

All channels are identical and fully independent. All outputs are registered.

- **Synchronizer.** Two flops per channel. Each flop resets to 1 (released). `s` is the second flop's output, inverted, so 1 = pressed.
- **Debounce counter** (`dcnt`), evaluated each edge:
  - If `s == pressed`: `dcnt` ← 0.
  - Else if `dcnt == STABLE_CYCLES-1`: `pressed` ← `s`, `dcnt` ← 0, and the matching pulse (`press_p` or `release_p`) is 1 for that cycle.
  - Else: `dcnt` ← `dcnt + 1`.
  - Any single sample matching `pressed` restarts the count, so bounce shorter than `STABLE_CYCLES` is fully rejected.
- **Hold counter** (`hcnt`), two states per channel:
  - State IDLE:
    - Entered on reset and on release acceptance; `hcnt` = 0 and `held_long` = 0.
    - On press acceptance, go to HOLD with `hcnt` ← 0.
  - State HOLD (`pressed` = 1):
    - `hcnt` increments each edge.
    - When `hcnt == LONG_CYCLES-1`: `long_p` ← 1 for one cycle, `held_long` ← 1, and `hcnt` saturates with no further counting.
    - Release acceptance returns to IDLE.
- **Simultaneous events.** If release acceptance and the long threshold fall on the same edge, the release wins: no `long_p`, `held_long` stays 0.
- **Pulse exclusivity.** `press_p` and `release_p` never assert together on one channel. `long_p` fires at most once per press.

## Timing

- **Reset values.** `pressed`, `press_p`, `release_p`, `long_p` and `held_long` are all 0. Sync flops are 1; all counters are 0. Reset takes effect immediately, without waiting for a clock edge.
- **Reset mid-operation.** Any in-progress count is discarded and no pulse is emitted. After `rst` falls, a held button is treated as a fresh press.
- **Press/release latency.** Let the pin settle before edge E0. `pressed` and its pulse become visible after edge E0 + `STABLE_CYCLES` + 1: 2 edges for synchronization, then `STABLE_CYCLES` samples with the update on the last of them.
- **Long-press latency.** Let press acceptance occur at edge P. `long_p` and `held_long` become visible after edge P + `LONG_CYCLES`.
- **Pulse width.** Every pulse lasts exactly one clock cycle.

## Test plan

All scenarios use `N=2`, `STABLE_CYCLES=4`, `LONG_CYCLES=16`.

1. **Reset.** Assert `rst` while `nPB=2'b00` (both pins held) → all outputs 0 during reset. Release `rst` → `pressed=2'b11` and `press_p=2'b11` for one cycle, 5 edges after the first post-reset edge. No `release_p`.
2. **Clean press.** Drive `nPB[0]` 1→0 before edge E0 → `press_p[0]` is 1 only after edge E0+5. `pressed[0]` stays 1. Channel 1 is unaffected.
3. **Bounce rejection.** Toggle `nPB[0]` every 2 cycles for 20 cycles, then hold it at 0 → no pulses during the toggling. Exactly one `press_p[0]`, 5 edges after the final settle.
4. **Long press.** Hold `nPB[1]` at 0 for 40 cycles → `press_p[1]` at acceptance edge P. `long_p[1]` is a single pulse after edge P+16. `held_long[1]` is 1 from P+16 until release. Releasing gives `release_p[1]` 5 edges after the pin rises, with `held_long[1]` falling at that same edge.
5. **Short press.** Hold `nPB[0]` at 0 for 12 cycles, then 1 → `press_p[0]` and later `release_p[0]`. No `long_p[0]` and no `held_long[0]`.
6. **Reset mid-operation.** Assert `rst` for 1 cycle, 2 cycles into a debounce count → no pulse emitted. The count restarts from scratch after `rst` falls.
